// File: rtl/mips_mc_controller_if.sv
// Control interface between the multi-cycle MIPS controller and its datapath.
// The controller (master) consumes op/funct/zero and drives every select and enable.
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
    output alusrcb, pcsrc, alucontrol, illegal_op, state_dbg
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
    input  alusrcb, pcsrc, alucontrol, illegal_op, state_dbg
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM plus ALU decoder.
// Outputs decode from the current state; branch pcen additionally follows zero.
module mips_mc_controller #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  state_e state_q, state_d;

  logic       funct_legal;
  logic [3:0] funct_alu;
  logic       pcen, memwrite, irwrite, regwrite;
  logic       alusrca, iord, memtoreg, regdst, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;

  // Funct decode for R-type: ALU operation plus legality flag.
  always_comb begin
    funct_legal = 1'b1;
    funct_alu   = AluAdd;
    case (bus.funct)
      6'b100000: funct_alu = AluAdd;
      6'b100010: funct_alu = AluSub;
      6'b100100: funct_alu = AluAnd;
      6'b100101: funct_alu = AluOr;
      6'b100111: funct_alu = AluNor;
      6'b101010: funct_alu = AluSlt;
      default:   funct_legal = 1'b0;
    endcase
  end

  // Next-state selection; op/funct only matter in the decode-dependent states.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (bus.op == OpLw || bus.op == OpSw) begin
          state_d = StMemAdr;
        end else if (bus.op == OpRtype && funct_legal) begin
          state_d = StRtypeEx;
        end else if (bus.op == OpBeq || bus.op == OpBne) begin
          state_d = StBranch;
        end else if (bus.op == OpAddi || bus.op == OpSlti) begin
          state_d = StAddiEx;
        end else if (bus.op == OpJ) begin
          state_d = StJump;
        end else begin
          state_d = ILLEGAL_TRAP ? StTrap : StFetch;
        end
      end
      StMemAdr:  state_d = (bus.op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = StFetch;
      StRtypeEx: state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StBranch:  state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode from state; enables are suppressed for the whole reset cycle.
  always_comb begin
    pcen       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = AluAdd;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcen    = 1'b1;
      end
      StDecode: begin
        alusrcb    = 2'b11;
        illegal_op = !((bus.op == OpLw) || (bus.op == OpSw) ||
                       (bus.op == OpRtype && funct_legal) ||
                       (bus.op == OpBeq) || (bus.op == OpBne) ||
                       (bus.op == OpAddi) || (bus.op == OpSlti) || (bus.op == OpJ));
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StRtypeEx: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBranch: begin
        alusrca    = 1'b1;
        alucontrol = AluSub;
        pcsrc      = 2'b01;
        // beq takes the branch on equal, bne on not-equal.
        pcen       = (bus.op == OpBeq) ? bus.zero : !bus.zero;
      end
      StAddiEx: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = (bus.op == OpSlti) ? AluSlt : AluAdd;
      end
      StAddiWb: regwrite = 1'b1;
      StJump: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcen     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign bus.pcen       = pcen;
  assign bus.memwrite   = memwrite;
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal_op = illegal_op;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: directed steps plus random instruction stream,
// checked against a table-driven model of the instruction flow.
module tb_mips_mc_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_mc_controller_if if0 ();
  mips_mc_controller_if if1 ();

  mips_mc_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  mips_mc_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));

  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  assign if0.op = op;
  assign if0.funct = funct;
  assign if0.zero = zero;
  assign if1.op = op;
  assign if1.funct = funct;
  assign if1.zero = zero;

  // {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,alusrcb,pcsrc,alucontrol,illegal}
  logic [16:0] obs0, obs1;
  assign obs0 = {if0.pcen, if0.memwrite, if0.irwrite, if0.regwrite, if0.alusrca, if0.iord,
                 if0.memtoreg, if0.regdst, if0.alusrcb, if0.pcsrc, if0.alucontrol, if0.illegal_op};
  assign obs1 = {if1.pcen, if1.memwrite, if1.irwrite, if1.regwrite, if1.alusrca, if1.iord,
                 if1.memtoreg, if1.regdst, if1.alusrcb, if1.pcsrc, if1.alucontrol, if1.illegal_op};

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  logic [5:0] legal_ops   [8] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h02};
  logic [5:0] legal_functs[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
  logic [3:0] funct_codes [6] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hc, 4'h7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int funct_idx(input logic [5:0] f);
    for (int i = 0; i < 6; i++) if (legal_functs[i] == f) return i;
    return -1;
  endfunction

  function automatic bit instr_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) return funct_idx(f) >= 0;
    for (int i = 0; i < 8; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  // State visit list per instruction class (FETCH..last state before next FETCH).
  function automatic void build_seq(input logic [5:0] o, input logic [5:0] f);
    exp_q = '{0, 1};
    if (!instr_legal(o, f)) return;
    case (o)
      6'h23:        exp_q = '{0, 1, 2, 3, 4};
      6'h2b:        exp_q = '{0, 1, 2, 5};
      6'h00:        exp_q = '{0, 1, 6, 7};
      6'h04, 6'h05: exp_q = '{0, 1, 8};
      6'h08, 6'h0a: exp_q = '{0, 1, 9, 10};
      default:      exp_q = '{0, 1, 11};
    endcase
  endfunction

  // Expected control word for a state, written from the per-state control table.
  function automatic logic [16:0] exp_out(input int st, input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input logic r);
    logic pc = 0, mw = 0, ir = 0, rw = 0, sa = 0, io = 0, mr = 0, rd = 0, il = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [3:0] alu = 4'h2;
    case (st)
      0:  begin sb = 2'b01; ir = 1; pc = 1; end
      1:  begin sb = 2'b11; il = !instr_legal(o, f); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  io = 1;
      4:  begin mr = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; if (funct_idx(f) >= 0) alu = funct_codes[funct_idx(f)]; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alu = 4'h6; ps = 2'b01; pc = (o == 6'h04) ? z : !z; end
      9:  begin sa = 1; sb = 2'b10; alu = (o == 6'h0a) ? 4'h7 : 4'h2; end
      10: rw = 1;
      11: begin ps = 2'b10; pc = 1; end
      default: ;
    endcase
    if (r) begin pc = 0; mw = 0; ir = 0; rw = 0; end
    return {pc, mw, ir, rw, sa, io, mr, rd, sb, ps, alu, il};
  endfunction

  // Cursor convention: called at a negedge with dut0 in FETCH. Runs ncyc cycles (-1: all)
  // and, when complete, leaves the cursor at the negedge of the following FETCH.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input int zmode, input int ncyc);
    int n;
    build_seq(o, f);
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      op = o;
      funct = f;
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      #1;
      chk($sformatf("%s_st%0d", name, i), 32'(if0.state_dbg), 32'(exp_q[i]));
      chk($sformatf("%s_out%0d", name, i), 32'(obs0), 32'(exp_out(exp_q[i], o, f, zero, reset)));
    end
    if (ncyc < 0) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_en", 32'({if0.pcen, if0.memwrite, if0.irwrite, if0.regwrite}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ro, rf;
    @(negedge clk);
    // Reset and first FETCH
    do_reset();
    run_instr("lw", 6'h23, 6'h00, -1, -1);
    run_instr("sw", 6'h2b, 6'h11, -1, -1);
    run_instr("beq_t", 6'h04, 6'h00, 1, -1);
    run_instr("beq_n", 6'h04, 6'h00, 0, -1);
    run_instr("bne_t", 6'h05, 6'h00, 0, -1);
    run_instr("bne_n", 6'h05, 6'h00, 1, -1);
    run_instr("sub", 6'h00, 6'h22, -1, -1);
    run_instr("nor", 6'h00, 6'h27, -1, -1);
    run_instr("slti", 6'h0a, 6'h00, -1, -1);
    run_instr("addi", 6'h08, 6'h3f, -1, -1);
    run_instr("ill0", 6'h3f, 6'h00, -1, -1);
    run_instr("badfn", 6'h00, 6'h01, -1, -1);
    run_instr("j", 6'h02, 6'h00, -1, -1);

    // Reset in MEMRD of lw: enables off in that cycle, then FETCH
    run_instr("lwpart", 6'h23, 6'h00, -1, 4);
    reset = 1'b1;
    #1;
    chk("midrst_st", 32'(if0.state_dbg), 32'd3);
    chk("midrst_out", 32'(obs0), 32'(exp_out(3, op, funct, zero, 1'b1)));
    @(negedge clk);
    reset = 1'b0;
    run_instr("j_after", 6'h02, 6'h00, -1, -1);

    // Trap variant parks in TRAP with enables off until reset
    do_reset();
    chk("trap_rst", 32'(if1.state_dbg), 32'd0);
    op = 6'h3f;
    funct = 6'h00;
    #1;
    chk("trap_f", 32'(if1.state_dbg), 32'd0);
    @(negedge clk);
    #1;
    chk("trap_d", 32'(if1.state_dbg), 32'd1);
    chk("trap_ill", 32'(if1.illegal_op), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op = 6'($urandom);
      funct = 6'($urandom);
      zero = 1'($urandom);
      #1;
      chk($sformatf("trap_hold%0d", i), 32'(if1.state_dbg), 32'd12);
      chk($sformatf("trap_en%0d", i), 32'({if1.pcen, if1.memwrite, if1.irwrite, if1.regwrite}),
          32'd0);
    end
    @(negedge clk);
    do_reset();
    chk("trap_exit", 32'(if1.state_dbg), 32'd0);

    // Random instruction stream
    for (int k = 0; k < 60; k++) begin
      ro = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_functs[$urandom_range(0, 5)];
      run_instr($sformatf("rnd%0d", k), ro, rf, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
